// File: rtl/logic_gate_pipe_pkg.sv
// Shared opcode type and golden evaluation functions for the logic-gate pipeline.
// The vector form of logic_eval is the reference model used by assertions and benches.
package logic_gate_pkg;

    localparam int MAX_W = 64;

    typedef enum logic [2:0] {
        OP_NOT  = 3'd0,
        OP_AND  = 3'd1,
        OP_OR   = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XOR  = 3'd5,
        OP_XNOR = 3'd6,
        OP_BUF  = 3'd7
    } op_e;

    function automatic logic logic_eval_bit(input op_e op, input logic a, input logic b);
        logic r;
        case (op)
            OP_NOT:  r = ~a;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_NAND: r = ~(a & b);
            OP_NOR:  r = ~(a | b);
            OP_XOR:  r = a ^ b;
            OP_XNOR: r = ~(a ^ b);
            default: r = a;
        endcase
        return r;
    endfunction

    // Callers zero-extend narrower operands and keep only their low WIDTH bits.
    function automatic logic [MAX_W-1:0] logic_eval(input op_e op, input logic [MAX_W-1:0] a,
                                                    input logic [MAX_W-1:0] b);
        logic [MAX_W-1:0] r;
        case (op)
            OP_NOT:  r = ~a;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_NAND: r = ~(a & b);
            OP_NOR:  r = ~(a | b);
            OP_XOR:  r = a ^ b;
            OP_XNOR: r = ~(a ^ b);
            default: r = a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logic_gate_stage.sv
// Generic valid/ready register slice; advances when empty or when downstream accepts.
// Bubbles keep stale payload so only valid-qualified data is ever written.
module logic_gate_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         valid_reg;
    logic [W-1:0] data_reg;

    assign in_ready  = !valid_reg || out_ready;
    assign out_valid = valid_reg;
    assign out_data  = data_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (in_ready) begin
            valid_reg <= in_valid;
            if (in_valid) begin
                data_reg <= in_data;
            end
        end
    end

endmodule

// File: rtl/logic_gate_pipe.sv
// Two-stage handshaked bitwise logic unit with result flags and saturating completion counter.
// Define LOGIC_GATE_PIPE_ASSERT_EN to compile in self-check assertions (active while rst=1).
module logic_gate_pipe
    import logic_gate_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [2:0]       op_out,
    output logic             zero,
    output logic             ones,
    output logic [CNT_W-1:0] txn_cnt
);

    localparam int S1_W = 3 + 2 * WIDTH;
    localparam int S2_W = 3 + WIDTH + 2;

    logic             s1_valid;
    logic             s2_adv;
    logic [S1_W-1:0]  s1_data;
    logic [S2_W-1:0]  s2_in;
    logic [S2_W-1:0]  s2_data;
    op_e              s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [WIDTH-1:0] y_calc;
    logic [CNT_W-1:0] txn_cnt_reg;

    logic_gate_stage #(.W(S1_W)) u_s1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({op, a, b}),
        .out_valid (s1_valid),
        .out_ready (s2_adv),
        .out_data  (s1_data)
    );

    assign s1_op = op_e'(s1_data[S1_W-1 -: 3]);
    assign s1_a  = s1_data[2*WIDTH-1 -: WIDTH];
    assign s1_b  = s1_data[WIDTH-1:0];

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign y_calc[gi] = logic_eval_bit(s1_op, s1_a[gi], s1_b[gi]);
        end
    endgenerate

    // Flags are computed before S2 so outputs stay purely registered.
    assign s2_in = {s1_op, y_calc, ~|y_calc, &y_calc};

    logic_gate_stage #(.W(S2_W)) u_s2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s1_valid),
        .in_ready  (s2_adv),
        .in_data   (s2_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (s2_data)
    );

    assign op_out = s2_data[S2_W-1 -: 3];
    assign y      = s2_data[WIDTH+1:2];
    assign zero   = s2_data[1];
    assign ones   = s2_data[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            txn_cnt_reg <= '0;
        end else if (out_valid && out_ready && (txn_cnt_reg != {CNT_W{1'b1}})) begin
            txn_cnt_reg <= txn_cnt_reg + 1'b1;
        end
    end

    assign txn_cnt = txn_cnt_reg;

`ifdef LOGIC_GATE_PIPE_ASSERT_EN
    logic [MAX_W-1:0] gold_full;
    logic             chk_load_reg;
    logic [WIDTH-1:0] chk_y_reg;
    logic [WIDTH-1:0] chk_a_reg;
    logic [WIDTH-1:0] chk_b_reg;
    logic [2:0]       chk_op_reg;
    logic             hold_reg;
    logic [WIDTH-1:0] prev_y_reg;
    logic [2:0]       prev_op_reg;
    logic [CNT_W-1:0] prev_cnt_reg;

    assign gold_full = logic_eval(s1_op, MAX_W'(s1_a), MAX_W'(s1_b));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chk_load_reg <= 1'b0;
            chk_y_reg    <= '0;
            chk_a_reg    <= '0;
            chk_b_reg    <= '0;
            chk_op_reg   <= '0;
            hold_reg     <= 1'b0;
            prev_y_reg   <= '0;
            prev_op_reg  <= '0;
            prev_cnt_reg <= '0;
        end else begin
            chk_load_reg <= s1_valid && s2_adv;
            chk_y_reg    <= gold_full[WIDTH-1:0];
            chk_a_reg    <= s1_a;
            chk_b_reg    <= s1_b;
            chk_op_reg   <= s1_op;
            hold_reg     <= out_valid && !out_ready;
            prev_y_reg   <= y;
            prev_op_reg  <= op_out;
            prev_cnt_reg <= txn_cnt_reg;
        end
    end

    // Checks compare the registered snapshot of the previous edge with current outputs.
    always @(posedge clk) begin
        if (rst) begin
            if (chk_load_reg) begin
                assert (y == chk_y_reg)
                else $error("logic_gate_pipe: y=%h golden=%h op=%0d a=%h b=%h",
                            y, chk_y_reg, chk_op_reg, chk_a_reg, chk_b_reg);
            end
            if (out_valid) begin
                assert ((zero == (y == '0)) && (ones == (&y)))
                else $error("logic_gate_pipe: flags zero=%b ones=%b y=%h op=%0d",
                            zero, ones, y, op_out);
            end
            if (hold_reg) begin
                assert (out_valid && (y == prev_y_reg) && (op_out == prev_op_reg))
                else $error("logic_gate_pipe: stall not held op=%0d y=%h was op=%0d y=%h",
                            op_out, y, prev_op_reg, prev_y_reg);
            end
            assert (txn_cnt_reg >= prev_cnt_reg)
            else $error("logic_gate_pipe: txn_cnt fell %0d -> %0d op=%0d y=%h",
                        prev_cnt_reg, txn_cnt_reg, op_out, y);
        end
    end
`endif

endmodule

// File: doc/logic_gate_pipe.md
Name: logic_gate_pipe

Overview:
- Parametrised, handshaked successor to the single-bit registered gate block: applies one of eight bitwise logic operations, selected per transaction by an opcode, to WIDTH-bit operands.
- Two-stage valid/ready pipeline with full backpressure, result flags and a saturating transaction counter.
- Sits between an operand source and a result consumer in the logic-unit datapath; also the assertion-practice target for the gates family.

Parameters:
- WIDTH, 8, operand/result width in bits (>=1).
- CNT_W, 16, width of the completed-transaction counter (>=2).

Ports:
- clk  in  1  single clock; all state on posedge.
- rst  in  1  asynchronous, active-low reset (asserted at 0, takes effect immediately, released synchronously by design convention).
- in_valid  in  1  operand transaction valid.
- in_ready  out  1  block can accept operands this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op  in  3  opcode (op_e).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- y  out  WIDTH  result.
- op_out  out  3  opcode that produced y.
- zero  out  1  y == 0.
- ones  out  1  y == all ones.
- txn_cnt  out  CNT_W  completed output handshakes, saturating.

Behaviour:
- Opcodes: 0 NOT (~a), 1 AND, 2 OR, 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 BUF (y=a). b is ignored for NOT/BUF.
- Stage 1 (S1) registers a, b, op and v1. Stage 2 (S2) registers the computed y, op_out, zero, ones and v2.
- Outputs come directly from S2 registers. There is no combinational path from a/b/op to y.
- Handshake rules:
  - Input accepted on in_valid && in_ready.
  - Output consumed on out_valid && out_ready.
  - s2_adv = !v2 || out_ready.
  - s1_adv = !v1 || s2_adv.
  - in_ready = s1_adv (combinational from out_ready; no ready-to-ready loop beyond this).
- Latency: an accepted transaction appears at out_valid exactly 2 cycles after acceptance when not stalled. Throughput is 1 per cycle.
- Stall: with out_ready=0, S2 holds y/op_out/flags/out_valid stable. S1 fills, then in_ready drops. Accepted data is never lost or duplicated.
- Stall release: order is preserved strictly FIFO. The same cycle out_ready rises, S2 loads from S1 and S1 may accept new input.
- out_valid must not depend on out_ready. Once asserted it stays high until handshake.
- Bubbles: a stage with valid=0 retains stale data. Flags and y are don't-care while out_valid=0, but must still hold their reset value until the first transaction.
- txn_cnt increments by 1 on each output handshake and saturates at 2^CNT_W-1 (no wrap).
- Reset (rst=0), at any time including mid-stall:
  - v1, v2, out_valid, y, op_out, zero, txn_cnt all clear to 0; ones clears to 0.
  - In-flight transactions are discarded.
  - in_ready reads 1 during and after reset.
- Simultaneous input accept and output consume in one cycle is legal; occupancy is unchanged.

Optional Feature:
- Macro: LOGIC_GATE_PIPE_ASSERT_EN.
- When defined, the design includes immediate assertions in clocked always blocks, active only while rst=1:
  - On each S2 load, y equals a golden recompute from S1 fields.
  - zero == (y==0) and ones == (&y).
  - out_valid held with stable y/op_out while !out_ready.
  - txn_cnt never decreases except via reset.
  - Each failure calls $error with opcode and operands.
- When undefined, no assertion code is compiled and the RTL is functionally identical.

Decomposition:
- Package logic_gate_pkg holds:
  - typedef enum logic [2:0] op_e {OP_NOT, OP_AND, OP_OR, OP_NAND, OP_NOR, OP_XOR, OP_XNOR, OP_BUF}.
  - function logic_eval(op_e, a, b) parametrised by width via a let/automatic function, shared by RTL and bench as the golden model.
- One natural sub-module: logic_gate_stage, a generic valid/ready register slice (payload width parameter). It is instanced twice.

Test Plan:
- Reset then WIDTH=8, op=AND, a=8'hF0, b=8'h3C, out_ready=1 → out_valid at cycle +2, y=8'h30, zero=0, ones=0, txn_cnt=1.
- Sweep all 8 opcodes back-to-back with a=8'hA5, b=8'h0F, out_ready=1 → expected ys:
  - NOT 5A, AND 05, OR AF, NAND FA, NOR 50, XOR AA, XNOR 55, BUF A5.
  - One result per cycle, in order.
- out_ready=0 for 5 cycles while driving 3 transactions (NOR 00/00, XOR FF/00, AND 00/FF) → in_ready drops after 2 accepted; y=FF/ones=1 held stable. On release, outputs are FF, FF, 00 (zero=1) in order, then the third is accepted.
- Assert rst=0 mid-stall with both stages full → out_valid=0, txn_cnt=0, in_ready=1 immediately. No stale result appears after release.
- CNT_W=2, 5 completed transactions → txn_cnt reads 1,2,3,3,3.
- Random valid/ready toggling, 10k transactions, with LOGIC_GATE_PIPE_ASSERT_EN defined → scoreboard vs logic_eval matches and zero assertion failures. Injected corrupted y via force triggers exactly one $error.
